// File: rtl/pipe_mem_access_if.sv
// pipe_mem_access_if: EX/MEM inputs, data-memory port and MEM/WB result bundle
interface pipe_mem_access_if;
  logic        ex_valid;
  logic        ex_load;
  logic        ex_store;
  logic        ex_regwrite;
  logic        ex_signed;
  logic [1:0]  ex_size;
  logic [31:0] ex_addr;
  logic [31:0] ex_wdata;
  logic [4:0]  ex_rd;
  logic [31:0] mem_rdata;
  logic [4:0]  DataAdr;
  logic [31:0] DataIn;
  logic        DMemW;
  logic        DMemR;
  logic        stall;
  logic        wb_valid;
  logic        wb_regwrite;
  logic        wb_misalign;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  modport slave (
    input  ex_valid, ex_load, ex_store, ex_regwrite, ex_signed, ex_size, ex_addr, ex_wdata, ex_rd, mem_rdata,
    output DataAdr, DataIn, DMemW, DMemR, stall, wb_valid, wb_regwrite, wb_misalign, wb_rd, wb_data
  );
  modport master (
    output ex_valid, ex_load, ex_store, ex_regwrite, ex_signed, ex_size, ex_addr, ex_wdata, ex_rd, mem_rdata,
    input  DataAdr, DataIn, DMemW, DMemR, stall, wb_valid, wb_regwrite, wb_misalign, wb_rd, wb_data
  );
endinterface

// File: rtl/pipe_mem_access.sv
// pipe_mem_access: MEM pipeline stage; define PIPE_MEM_SUBWORD_EN for byte/half access via read-modify-write
module pipe_mem_access (
  input logic              clk,
  input logic              rst,
  pipe_mem_access_if.slave bus
);
  logic        w_mem, w_store, w_load, w_word, w_mis, w_rmw, w_sub_st, w_mem_ok;
  logic [31:0] w_ld, w_din;
  logic [4:0]  w_adr, w_rmw_rd;
  logic        r_wb_valid, r_wb_regwrite, r_wb_misalign;
  logic [4:0]  r_wb_rd;
  logic [31:0] r_wb_data;
  assign w_mem   = bus.ex_load | bus.ex_store;
  assign w_store = bus.ex_store;
  assign w_load  = bus.ex_load & ~bus.ex_store;
`ifdef PIPE_MEM_SUBWORD_EN
  typedef enum logic {IDLE, RMW} state_t;
  state_t      r_state, w_next;
  logic        w_half;
  logic [4:0]  w_sh, r_adr, r_rd;
  logic [15:0] w_lane;
  logic [31:0] w_mask, w_merge, r_merge;
  assign w_word   = bus.ex_size[1];
  assign w_half   = bus.ex_size == 2'b01;
  assign w_mis    = w_mem & ((w_half & bus.ex_addr[0]) | (w_word & |bus.ex_addr[1:0]));
  assign w_rmw    = r_state == RMW;
  assign w_sh     = {bus.ex_addr[1:0], 3'b000};
  assign w_lane   = 16'(bus.mem_rdata >> w_sh);
  assign w_ld     = w_word ? bus.mem_rdata :
                    w_half ? {{16{bus.ex_signed & w_lane[15]}}, w_lane} :
                             {{24{bus.ex_signed & w_lane[7]}}, w_lane[7:0]};
  assign w_mask   = (w_half ? 32'h0000_FFFF : 32'h0000_00FF) << w_sh;
  assign w_merge  = (bus.mem_rdata & ~w_mask) | ((bus.ex_wdata << w_sh) & w_mask);
  assign w_sub_st = ~w_rmw & bus.ex_valid & w_store & ~w_mis & ~w_word;
  assign w_adr    = w_rmw ? r_adr : bus.ex_addr[6:2];
  assign w_din    = w_rmw ? r_merge : bus.ex_wdata;
  assign w_rmw_rd = r_rd;
  // state register; reset drops any pending RMW write
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  // an accepted aligned sub-word store reads first, then writes for exactly one cycle
  always_comb begin
    w_next = w_sub_st ? RMW : IDLE;
  end
  // hold the merged word, its address and destination for the write cycle
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_merge <= '0;
      r_adr   <= '0;
      r_rd    <= '0;
    end else if (w_sub_st) begin
      r_merge <= w_merge;
      r_adr   <= bus.ex_addr[6:2];
      r_rd    <= bus.ex_rd;
    end
`else
  logic w_unused;
  assign w_word   = 1'b1;
  assign w_mis    = w_mem & |bus.ex_addr[1:0];
  assign w_rmw    = 1'b0;
  assign w_sub_st = 1'b0;
  assign w_ld     = bus.mem_rdata;
  assign w_adr    = bus.ex_addr[6:2];
  assign w_din    = bus.ex_wdata;
  assign w_rmw_rd = 5'd0;
  assign w_unused = ^{bus.ex_size, bus.ex_signed};
`endif
  assign w_mem_ok = ~w_rmw & bus.ex_valid & w_mem & ~w_mis;
  // memory port strobes, silenced while reset is held so an interrupted RMW never writes
  always_comb begin
    bus.DataAdr = w_adr;
    bus.DataIn  = w_din;
    bus.DMemW   = ~rst & (w_rmw | (w_mem_ok & w_store & w_word));
    bus.DMemR   = ~rst & w_mem_ok & ~(w_store & w_word);
    bus.stall   = ~rst & w_sub_st;
  end
  // MEM/WB result register; the read half of an RMW produces no result
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_wb_valid    <= 1'b0;
      r_wb_regwrite <= 1'b0;
      r_wb_misalign <= 1'b0;
      r_wb_rd       <= '0;
      r_wb_data     <= '0;
    end else if (w_rmw) begin
      r_wb_valid    <= 1'b1;
      r_wb_regwrite <= 1'b0;
      r_wb_misalign <= 1'b0;
      r_wb_rd       <= w_rmw_rd;
      r_wb_data     <= '0;
    end else begin
      r_wb_valid    <= bus.ex_valid & ~w_sub_st;
      r_wb_regwrite <= bus.ex_valid & ~w_mis & ~w_store & bus.ex_regwrite;
      r_wb_misalign <= bus.ex_valid & w_mis;
      r_wb_rd       <= (bus.ex_valid && !w_sub_st) ? bus.ex_rd : 5'd0;
      r_wb_data     <= (!bus.ex_valid || w_mis || w_store) ? 32'd0 : w_load ? w_ld : bus.ex_addr;
    end
  assign bus.wb_valid    = r_wb_valid;
  assign bus.wb_regwrite = r_wb_regwrite;
  assign bus.wb_misalign = r_wb_misalign;
  assign bus.wb_rd       = r_wb_rd;
  assign bus.wb_data     = r_wb_data;
endmodule
